// File: rtl/clk_frac_div_ctrl_if.sv
// Divisor configuration handshake between a host and the
// fractional clock divider controller.
interface clk_frac_div_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_err;

  modport master (
    output cfg_valid,
    output cfg_div,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_div,
    output cfg_ready,
    output cfg_err
  );
endinterface

// File: rtl/clk_frac_div_ctrl.sv
// Sequencer for the half-integer clock divider flops.
// Owns phase counter and divisor; changes apply on frame edges.
module clk_frac_div_ctrl #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  clk_frac_div_ctrl_if.slave     cfg,
  output logic                   pos_set,
  output logic                   neg_set,
  output logic                   frame_start,
  output logic                   busy,
  output logic [CNT_W-1:0]       cur_div
);

  localparam logic [CNT_W-1:0] LP_DEF = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] LP_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] LP_MIN = CNT_W'(3);

  typedef enum logic [1:0] {
    S_OFF,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] r_pend_div;
  logic             r_pend;
  logic             r_err;

  logic [CNT_W-1:0] w_half;
  logic [CNT_W-1:0] w_len;
  logic             w_odd;
  logic             w_active;
  logic             w_last;
  logic             w_xfer;
  logic             w_load;

  assign w_odd    = r_div[0];
  assign w_half   = r_div >> 1;
  assign w_len    = w_odd ? r_div : w_half;
  assign w_active = (r_state != S_OFF);
  assign w_last   = w_active && (r_cnt == w_len - LP_ONE);
  assign w_xfer   = cfg.cfg_valid & ~r_pend;
  assign w_load   = w_xfer && (cfg.cfg_div >= LP_MIN);

  assign cfg.cfg_ready = ~r_pend;
  assign cfg.cfg_err   = r_err;
  assign cur_div       = r_div;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_OFF;
    else     r_state <= w_state_nxt;
  end

  // Next state: stop requests always finish the current frame
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_OFF:   if (enable) w_state_nxt = S_RUN;
      S_RUN:   if (!enable)
                 w_state_nxt = w_last ? S_OFF : S_DRAIN;
      S_DRAIN: if (w_last) w_state_nxt = S_OFF;
      default: w_state_nxt = S_OFF;
    endcase
  end

  // Set enables decoded from phase and divisor
  always_comb begin
    busy        = w_active;
    frame_start = w_active && (r_cnt == '0);
    pos_set     = 1'b0;
    neg_set     = 1'b0;
    if (w_active) begin
      if (w_odd) begin
        pos_set = (r_cnt == '0) ||
                  (r_cnt == w_half + LP_ONE);
        neg_set = (r_cnt == LP_ONE) ||
                  (r_cnt == w_half + LP_ONE);
      end else if (w_half == LP_ONE) begin
        pos_set = (r_cnt == '0);
      end else begin
        pos_set = (r_cnt < (w_half >> 1));
      end
    end
  end

  // Phase counter, divisor, pending slot and error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_div      <= LP_DEF;
      r_pend_div <= LP_DEF;
      r_pend     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_xfer & ~w_load;
      if (!w_active || w_last) r_cnt <= '0;
      else                     r_cnt <= r_cnt + LP_ONE;
      if (!w_active) begin
        if (w_load) r_div <= cfg.cfg_div;
      end else if (w_last) begin
        if (w_load) begin
          r_div <= cfg.cfg_div;
        end else if (r_pend) begin
          r_div  <= r_pend_div;
          r_pend <= 1'b0;
        end
      end else if (w_load) begin
        r_pend     <= 1'b1;
        r_pend_div <= cfg.cfg_div;
      end
    end
  end

endmodule
